// File: rtl/div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_pkg
// Description : Shared encodings for the RV32M iterative divider.
// Revision    : 1.0 - initial release
// ============================================================================
package div_unit_pkg;

    localparam int c_XLEN = 32;

    typedef logic [1:0] div_op_t;

    // funct3[1:0] of the divide-class instructions
    localparam div_op_t c_DIV_OP_DIV  = 2'b00;
    localparam div_op_t c_DIV_OP_DIVU = 2'b01;
    localparam div_op_t c_DIV_OP_REM  = 2'b10;
    localparam div_op_t c_DIV_OP_REMU = 2'b11;

    localparam logic [6:0] c_OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] c_FUNCT7_MULDIV = 7'b0000001;

    localparam logic [1:0] c_DIV_ST_IDLE = 2'd0;
    localparam logic [1:0] c_DIV_ST_ITER = 2'd1;
    localparam logic [1:0] c_DIV_ST_FIX  = 2'd2;
    localparam logic [1:0] c_DIV_ST_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One radix-2 restoring division step (combinational).
// Revision    : 1.0 - initial release
// ============================================================================
module div_step
    import div_unit_pkg::*;
#(
    parameter int XLEN = c_XLEN
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] w_shifted;
    logic [XLEN:0] w_diff;
    logic          w_borrow;

    // The quotient register doubles as the dividend shifter: its MSB feeds the remainder.
    assign w_shifted = {rem_in, quo_in[XLEN-1]};
    assign w_diff    = w_shifted - {1'b0, divisor};
    assign w_borrow  = w_diff[XLEN];

    assign rem_out = w_borrow ? w_shifted[XLEN-1:0] : w_diff[XLEN-1:0];
    assign quo_out = {quo_in[XLEN-2:0], ~w_borrow};

endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Iterative RV32M divider (DIV/DIVU/REM/REMU) for the EX stage.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN = c_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            div_valid,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            ex_hold,
    input  logic            kill,
    output logic            div_stall,
    output logic            div_busy,
    output logic            div_done,
    output logic [XLEN-1:0] div_result
);

    localparam int              CNT_W      = $clog2(XLEN);
    localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  c_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]       r_state;
    logic [1:0]       r_op;
    logic             r_sign_a;
    logic             r_sign_b;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_divisor;
    logic [CNT_W-1:0] r_count;
    logic [XLEN-1:0]  r_result;

    logic             w_is_signed;
    logic             w_sign_a;
    logic             w_sign_b;
    logic [XLEN-1:0]  w_abs_a;
    logic [XLEN-1:0]  w_abs_b;
    logic             w_div_zero;
    logic             w_overflow;
    logic [XLEN-1:0]  w_special;
    logic [XLEN-1:0]  w_rem_step;
    logic [XLEN-1:0]  w_quo_step;
    logic [XLEN-1:0]  w_quo_fix;
    logic [XLEN-1:0]  w_rem_fix;

    // Unsigned ops leave both sign flags clear, so FIX never negates for them.
    assign w_is_signed = ~div_op[0];
    assign w_sign_a    = w_is_signed & operand_a[XLEN-1];
    assign w_sign_b    = w_is_signed & operand_b[XLEN-1];
    assign w_abs_a     = w_sign_a ? -operand_a : operand_a;
    assign w_abs_b     = w_sign_b ? -operand_b : operand_b;

    assign w_div_zero = (operand_b == '0);
    assign w_overflow = w_is_signed & (operand_a == c_INT_MIN) & (operand_b == '1);

    always_comb begin
        w_special = '0;
        if (w_div_zero) begin
            w_special = div_op[1] ? operand_a : '1;
        end else begin
            w_special = div_op[1] ? '0 : c_INT_MIN;
        end
    end

    div_step #(
        .XLEN (XLEN)
    ) u_div_step (
        .rem_in  (r_rem),
        .quo_in  (r_quo),
        .divisor (r_divisor),
        .rem_out (w_rem_step),
        .quo_out (w_quo_step)
    );

    assign w_quo_fix = ((r_op == c_DIV_OP_DIV) & (r_sign_a ^ r_sign_b)) ? -r_quo : r_quo;
    assign w_rem_fix = ((r_op == c_DIV_OP_REM) & r_sign_a) ? -r_rem : r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_DIV_ST_IDLE;
            r_op      <= '0;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_count   <= '0;
            r_result  <= '0;
        end else if (kill) begin
            r_state <= c_DIV_ST_IDLE;
        end else begin
            case (r_state)
                c_DIV_ST_IDLE: begin
                    if (div_valid) begin
                        r_op      <= div_op;
                        r_sign_a  <= w_sign_a;
                        r_sign_b  <= w_sign_b;
                        r_quo     <= w_abs_a;
                        r_divisor <= w_abs_b;
                        r_rem     <= '0;
                        r_count   <= c_CNT_INIT;
                        if (w_div_zero || w_overflow) begin
                            r_result <= w_special;
                            r_state  <= c_DIV_ST_DONE;
                        end else begin
                            r_state  <= c_DIV_ST_ITER;
                        end
                    end
                end
                c_DIV_ST_ITER: begin
                    r_rem <= w_rem_step;
                    r_quo <= w_quo_step;
                    if (r_count == '0) begin
                        r_state <= c_DIV_ST_FIX;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                c_DIV_ST_FIX: begin
                    r_result <= r_op[1] ? w_rem_fix : w_quo_fix;
                    r_state  <= c_DIV_ST_DONE;
                end
                default: begin
                    // Hold the result until EX is free to consume it.
                    if (!ex_hold) begin
                        r_state <= c_DIV_ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign div_stall  = ((r_state == c_DIV_ST_IDLE) & div_valid & ~kill) |
                        (r_state == c_DIV_ST_ITER) | (r_state == c_DIV_ST_FIX);
    assign div_busy   = (r_state != c_DIV_ST_IDLE);
    assign div_done   = (r_state == c_DIV_ST_DONE);
    assign div_result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Scoreboard testbench for the iterative RV32M divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;
    import div_unit_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            div_valid;
    logic [1:0]      div_op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            ex_hold;
    logic            kill;
    logic            div_stall;
    logic            div_busy;
    logic            div_done;
    logic [XLEN-1:0] div_result;

    div_unit #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_valid  (div_valid),
        .div_op     (div_op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .ex_hold    (ex_hold),
        .kill       (kill),
        .div_stall  (div_stall),
        .div_busy   (div_busy),
        .div_done   (div_done),
        .div_result (div_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every cycle the DUT presents a result, pops when EX advances.
    initial begin : g_monitor
        exp_t e;
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && div_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb[0];
                    check("result", div_result, e.res);
                    if (!prev_done) check("latency", 32'(cyc - e.acc), 32'(e.lat));
                    if (!ex_hold) e = sb.pop_front();
                end
            end
            prev_done = div_done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        if (b == 32'd0) begin
            r = op[1] ? a : 32'hFFFF_FFFF;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = op[1] ? 32'd0 : 32'h8000_0000;
        end else begin
            case (op)
                c_DIV_OP_DIV:  r = $signed(a) / $signed(b);
                c_DIV_OP_DIVU: r = a / b;
                c_DIV_OP_REM:  r = $signed(a) % $signed(b);
                default:       r = a % b;
            endcase
        end
        return r;
    endfunction

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit special, input int hold);
        int n;
        bit seen;
        exp_t e;
        tick();
        div_valid = 1'b1;
        div_op    = op;
        operand_a = a;
        operand_b = b;
        e.res = exp;
        e.acc = cyc;
        e.lat = special ? 1 : 34;
        sb.push_back(e);
        #1;
        n    = div_stall ? 1 : 0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i == 0) begin
                div_valid = 1'b0;
                operand_a = $urandom;
                operand_b = $urandom;
            end
            #1;
            if (div_done) begin
                seen = 1'b1;
                break;
            end
            if (div_stall) n++;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("stall_cycles", 32'(n), special ? 32'd1 : 32'd34);
        if (hold > 0) begin
            ex_hold = 1'b1;
            for (int k = 1; k <= hold; k++) begin
                tick();
                #1;
                check("hold_done", 32'(div_done), 32'd1);
                if (k == hold) ex_hold = 1'b0;
            end
            tick();
            #1;
            check("hold_exit_done", 32'(div_done), 32'd0);
            check("hold_exit_busy", 32'(div_busy), 32'd0);
        end
    endtask

    // Starts an op that will be aborted; nothing is expected from it.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        tick();
        div_valid = 1'b1;
        div_op    = op;
        operand_a = a;
        operand_b = b;
        tick();
        div_valid = 1'b0;
    endtask

    initial begin : g_stim
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bit          special;

        rst = 1'b1; div_valid = 1'b0; div_op = 2'b00; operand_a = '0; operand_b = '0;
        ex_hold = 1'b0; kill = 1'b0;
        repeat (3) tick();
        #1;
        check("rst_stall",  32'(div_stall), 32'd0);
        check("rst_busy",   32'(div_busy),  32'd0);
        check("rst_done",   32'(div_done),  32'd0);
        check("rst_result", div_result,     32'd0);
        rst = 1'b0;

        do_op(c_DIV_OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 0);
        do_op(c_DIV_OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 0);
        do_op(c_DIV_OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 1'b0, 0);
        do_op(c_DIV_OP_REMU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 1'b0, 0);
        do_op(c_DIV_OP_DIV,  32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        do_op(c_DIV_OP_REM,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b1, 0);
        do_op(c_DIV_OP_DIVU, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        do_op(c_DIV_OP_REMU, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b1, 0);
        do_op(c_DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 0);
        do_op(c_DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);
        do_op(c_DIV_OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 0);
        do_op(c_DIV_OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0);
        do_op(c_DIV_OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 0);
        do_op(c_DIV_OP_REM,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
        do_op(c_DIV_OP_DIV,  32'hFFFF_FFEC, 32'hFFFF_FFFA, 32'h0000_0003, 1'b0, 0);
        do_op(c_DIV_OP_REM,  32'hFFFF_FFEC, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 1'b0, 0);

        do_op(c_DIV_OP_DIVU, 32'd1000, 32'd9, 32'd111, 1'b0, 3);
        do_op(c_DIV_OP_REM,  32'd9,    32'd0, 32'd9,   1'b1, 2);

        // Kill in the tenth ITER cycle; after start_op we sit in ITER cycle 1.
        start_op(c_DIV_OP_DIV, 32'd1000, 32'd3);
        repeat (9) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        #1;
        check("kill_busy",  32'(div_busy),  32'd0);
        check("kill_stall", 32'(div_stall), 32'd0);
        check("kill_done",  32'(div_done),  32'd0);
        repeat (40) tick();
        do_op(c_DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 0);

        tick();
        div_valid = 1'b1;
        kill      = 1'b1;
        #1;
        check("kill_idle_stall", 32'(div_stall), 32'd0);
        tick();
        div_valid = 1'b0;
        kill      = 1'b0;
        #1;
        check("kill_idle_busy", 32'(div_busy), 32'd0);

        start_op(c_DIV_OP_DIVU, 32'd100, 32'd7);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_stall",  32'(div_stall), 32'd0);
        check("midrst_busy",   32'(div_busy),  32'd0);
        check("midrst_done",   32'(div_done),  32'd0);
        check("midrst_result", div_result,     32'd0);

        for (int i = 0; i < 150; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2, 3:    b = 32'($urandom_range(1, 255));
                4:       b = -32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            special = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
            do_op(op, a, b, ref_model(op, a, b), special, 0);
        end

        repeat (3) tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
